cache_assoc_ctrl: RTL and testbench
===================================

Name: cache_assoc_ctrl

Overview:
- Parametrised N-way set-associative cacheline store with a registered lookup pipeline, per-set round-robin victim selection, line fill, word write-through and a sequenced flush.
- Successor to the fixed 8-way, 1024-line, combinational-read cache array.
- Sits between the BDI decompression/fill path and the core load path.
- Way count, set count, tag and line width are generic.

Parameters:
- WAYS, 8, associativity; power of two, >=2.
- SETS, 128, sets per way; power of two.
- TAG_FIELD, 20, tag width in bits.
- WORD_WIDTH, 32, word width in bits.
- WORDS_PER_LINE, 8, words per cacheline; power of two.
- Derived, not overridable:
  - IDX_W = $clog2(SETS)
  - WAY_W = $clog2(WAYS)
  - WSEL_W = $clog2(WORDS_PER_LINE)
  - LINE_W = WORD_WIDTH*WORDS_PER_LINE

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  lookup accepted when high with lookup_valid
- lookup_index  in  IDX_W  set index
- lookup_tag  in  TAG_FIELD  request tag
- lookup_word  in  WSEL_W  word within line
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  hit flag
- resp_way  out  WAY_W  hitting way (0 on miss)
- resp_data  out  WORD_WIDTH  selected word (0 on miss)
- fill_valid  in  1  full-line fill request
- fill_ready  out  1  fill accepted when high with fill_valid
- fill_index  in  IDX_W  set to fill
- fill_tag  in  TAG_FIELD  tag of filled line
- fill_data  in  LINE_W  line data, word 0 in LSBs
- fill_way  out  WAY_W  combinational victim way for fill_index
- wr_valid  in  1  single-word write strobe
- wr_index  in  IDX_W  set
- wr_way  in  WAY_W  way
- wr_word  in  WSEL_W  word select
- wr_data  in  WORD_WIDTH  word data
- flush_req  in  1  start invalidate-all
- flush_busy  out  1  flush sequence in progress

Behaviour:
- Storage:
  - Valid bit and round-robin pointer per set are flops, reset to 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, FLUSH. Reset state is IDLE.
- lookup_ready = fill_ready = (state==IDLE).
- Output reset values: resp_valid=0, resp_hit=0, resp_way=0, resp_data=0, flush_busy=0.
- Lookup:
  - Accepted on lookup_valid & lookup_ready.
  - Response is registered: resp_valid=1 exactly one cycle after acceptance, 0 otherwise.
  - Throughput is one lookup per cycle.
  - Hit = valid[way][index] & tag match.
  - If multiple ways match, the lowest way wins.
  - On miss: resp_way=0, resp_data=0.
- Fill:
  - Victim is the lowest-numbered invalid way in the set if one exists; the pointer does not advance.
  - Otherwise the victim is pointer[set]; the pointer then advances by 1 and wraps WAYS-1 -> 0.
  - On acceptance: tag and data are written, valid set to 1, at the same edge.
- Word write:
  - Applied in IDLE only, and only if valid[wr_way][wr_index]=1; otherwise dropped.
  - Does not alter valid bits or the pointer.
- Same-cycle ordering:
  - A lookup reads pre-edge contents (read-before-write) for fill or write to the same set.
  - Fill and wr_valid to the same set/way in the same cycle: the fill wins, the word write is dropped.
- flush_req:
  - Sampled in IDLE only.
  - flush_req together with lookup/fill in the same cycle: the lookup/fill is accepted first, and FLUSH begins next cycle.
- FLUSH:
  - Counter from 0 clears all ways' valid bits and the pointer for one set per cycle.
  - Lasts exactly SETS cycles, then returns to IDLE.
  - flush_busy=1 throughout.
  - flush_req during FLUSH is ignored.
- Reset mid-flush or mid-lookup:
  - Immediate return to IDLE; all valids and pointers = 0; resp_valid=0.

Optional Feature:
- Macro: CACHE_ASSOC_PERF_COUNTERS_EN.
- When defined, adds outputs hit_count[31:0] and miss_count[31:0]:
  - Incremented on each resp_valid with resp_hit=1 / resp_hit=0 respectively.
  - Saturate at 32'hFFFF_FFFF.
  - Reset to 0 and cleared on the first FLUSH cycle.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then lookup idx=5 tag=0x12345 -> next cycle resp_valid=1, resp_hit=0, resp_data=0.
- Fill idx=5 tag=0x12345 with word k = 0xA000_0000+k, then lookup word 3 -> resp_hit=1, resp_way=0, resp_data=0xA000_0003.
- Nine fills to set 7, tags 1..9 (WAYS=8):
  - fill_way goes 0..7, then 0.
  - Tag 1 then misses and tag 9 hits in way 0.
  - pointer[7]=1.
- wr_valid idx=5 way=0 word=3 data=0xDEADBEEF, then lookup -> 0xDEADBEEF.
- wr_valid to an invalid way, then fill of that way -> the write leaves no effect on the filled data.
- flush_req with SETS=128:
  - flush_busy high exactly 128 cycles; lookup_ready and fill_ready low throughout.
  - Afterwards all prior tags miss.
  - rst asserted at flush cycle 40 -> flush_busy=0 immediately.

Source files
------------

// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: N-way set-associative line store with registered lookup, round-robin fill and sequenced flush.
// Optional hit/miss counters are enabled by defining CACHE_ASSOC_PERF_COUNTERS_EN.
module cache_assoc_ctrl #(
  parameter int WAYS           = 8,
  parameter int SETS           = 128,
  parameter int TAG_FIELD      = 20,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS),
  localparam int WSEL_W = $clog2(WORDS_PER_LINE),
  localparam int LINE_W = WORD_WIDTH*WORDS_PER_LINE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic [IDX_W-1:0]      lookup_index_i,
  input  logic [TAG_FIELD-1:0]  lookup_tag_i,
  input  logic [WSEL_W-1:0]     lookup_word_i,
  output logic                  resp_valid_o,
  output logic                  resp_hit_o,
  output logic [WAY_W-1:0]      resp_way_o,
  output logic [WORD_WIDTH-1:0] resp_data_o,
  input  logic                  fill_valid_i,
  output logic                  fill_ready_o,
  input  logic [IDX_W-1:0]      fill_index_i,
  input  logic [TAG_FIELD-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0]     fill_data_i,
  output logic [WAY_W-1:0]      fill_way_o,
  input  logic                  wr_valid_i,
  input  logic [IDX_W-1:0]      wr_index_i,
  input  logic [WAY_W-1:0]      wr_way_i,
  input  logic [WSEL_W-1:0]     wr_word_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o
`ifdef CACHE_ASSOC_PERF_COUNTERS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
`endif
);
  typedef enum logic {IDLE, FLUSH} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAY_W-1:0] ptr_q;
  logic [TAG_FIELD-1:0] tag_q [WAYS][SETS];
  logic [LINE_W-1:0] data_q [WAYS][SETS];
  logic lk_acc, fill_acc, wr_en, hit;
  logic [WAY_W-1:0] hway;
  logic [LINE_W-1:0] hline;
  logic [WORD_WIDTH-1:0] hdata;
  logic resp_valid_q, resp_hit_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [WORD_WIDTH-1:0] resp_data_q;
  assign lookup_ready_o = (state_q == IDLE);
  assign fill_ready_o   = (state_q == IDLE);
  assign flush_busy_o   = (state_q == FLUSH);
  assign lk_acc   = lookup_valid_i & lookup_ready_o;
  assign fill_acc = fill_valid_i & fill_ready_o;
  // A fill landing on the same line as the word write supersedes it
  assign wr_en = wr_valid_i & lookup_ready_o & valid_q[wr_index_i][wr_way_i] &
                 ~(fill_acc & (fill_index_i == wr_index_i) & (fill_way_o == wr_way_i));
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_way_o   = resp_way_q;
  assign resp_data_o  = resp_data_q;
  // Descending scans leave the lowest matching / invalid way as the winner
  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (valid_q[lookup_index_i][w] && tag_q[w][lookup_index_i] == lookup_tag_i) begin
        hit  = 1'b1;
        hway = WAY_W'(w);
      end
    hline = data_q[hway][lookup_index_i];
    hdata = hline[lookup_word_i*WORD_WIDTH +: WORD_WIDTH];
  end
  always_comb begin
    fill_way_o = ptr_q[fill_index_i];
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_q[fill_index_i][w]) fill_way_o = WAY_W'(w);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = flush_req_i ? FLUSH : IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d   = cnt_q + IDX_W'(1);
      state_d = (cnt_q == IDX_W'(SETS-1)) ? IDLE : FLUSH;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      ptr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q  <= 1'b0;
      resp_way_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_valid_q <= lk_acc;
      resp_hit_q  <= lk_acc & hit;
      resp_way_q  <= lk_acc ? hway : '0;
      resp_data_q <= (lk_acc && hit) ? hdata : '0;
      if (state_q == FLUSH) begin
        valid_q[cnt_q] <= '0;
        ptr_q[cnt_q]   <= '0;
      end else if (fill_acc) begin
        valid_q[fill_index_i][fill_way_o] <= 1'b1;
        if (&valid_q[fill_index_i]) ptr_q[fill_index_i] <= ptr_q[fill_index_i] + WAY_W'(1);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (fill_acc) begin
      tag_q[fill_way_o][fill_index_i]  <= fill_tag_i;
      data_q[fill_way_o][fill_index_i] <= fill_data_i;
    end
    if (wr_en) data_q[wr_way_i][wr_index_i][wr_word_i*WORD_WIDTH +: WORD_WIDTH] <= wr_data_i;
  end
`ifdef CACHE_ASSOC_PERF_COUNTERS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state_q == FLUSH && cnt_q == '0) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (resp_valid_q) begin
      if (resp_hit_q && !(&hit_count_o)) hit_count_o <= hit_count_o + 32'd1;
      if (!resp_hit_q && !(&miss_count_o)) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// tb_cache_assoc_ctrl: vector table, corner sequences and randomized traffic against an array-based cache model.
module tb_cache_assoc_ctrl;
  localparam int W = 8, S = 128, TF = 20, WW = 32, WPL = 8;
  localparam int IW = 7, AW = 3, SW = 3, LW = WW*WPL;
  logic clk = 0, rst_ni = 0;
  logic lookup_valid_i = 0, lookup_ready_o;
  logic [IW-1:0] lookup_index_i = 0;
  logic [TF-1:0] lookup_tag_i = 0;
  logic [SW-1:0] lookup_word_i = 0;
  logic resp_valid_o, resp_hit_o;
  logic [AW-1:0] resp_way_o;
  logic [WW-1:0] resp_data_o;
  logic fill_valid_i = 0, fill_ready_o;
  logic [IW-1:0] fill_index_i = 0;
  logic [TF-1:0] fill_tag_i = 0;
  logic [LW-1:0] fill_data_i = 0;
  logic [AW-1:0] fill_way_o;
  logic wr_valid_i = 0;
  logic [IW-1:0] wr_index_i = 0;
  logic [AW-1:0] wr_way_i = 0;
  logic [SW-1:0] wr_word_i = 0;
  logic [WW-1:0] wr_data_i = 0;
  logic flush_req_i = 0, flush_busy_o;
`ifdef CACHE_ASSOC_PERF_COUNTERS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  cache_assoc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_index_i(lookup_index_i), .lookup_tag_i(lookup_tag_i), .lookup_word_i(lookup_word_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o), .resp_data_o(resp_data_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_index_i(fill_index_i),
    .fill_tag_i(fill_tag_i), .fill_data_i(fill_data_i), .fill_way_o(fill_way_o),
    .wr_valid_i(wr_valid_i), .wr_index_i(wr_index_i), .wr_way_i(wr_way_i),
    .wr_word_i(wr_word_i), .wr_data_i(wr_data_i),
    .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o)
`ifdef CACHE_ASSOC_PERF_COUNTERS_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  bit mvalid [W][S];
  logic [TF-1:0] mtag [W][S];
  logic [WW-1:0] mdata [W][S][WPL];
  int mptr [S];
  int checks = 0, failures = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int victim(input int idx);
    for (int w = 0; w < W; w++) if (!mvalid[w][idx]) return w;
    return mptr[idx];
  endfunction

  task automatic model_clear();
    for (int w = 0; w < W; w++) for (int s = 0; s < S; s++) mvalid[w][s] = 0;
    for (int s = 0; s < S; s++) mptr[s] = 0;
  endtask

  task automatic model_lookup(input int idx, input logic [TF-1:0] tag, input int wd,
                              output bit h, output int wy, output logic [WW-1:0] d);
    h = 0; wy = 0; d = 0;
    for (int w = 0; w < W; w++)
      if (!h && mvalid[w][idx] && mtag[w][idx] == tag) begin
        h = 1; wy = w; d = mdata[w][idx][wd];
      end
  endtask

  bit mh; int mw; logic [WW-1:0] md; int mv;
  logic [AW-1:0] dfw;
  logic drdy;

  // One IDLE cycle with any mix of lookup/fill/write/flush; model updated with pre-edge semantics
  task automatic cyc(input bit lv, input int li, input logic [TF-1:0] lt, input int lw,
                     input bit fv, input int fi, input logic [TF-1:0] ft, input logic [LW-1:0] fl,
                     input bit wv, input int wi, input int wy, input int wd, input logic [WW-1:0] wdat,
                     input bit fr);
    bit wok, allv;
    lookup_valid_i = lv; lookup_index_i = li[IW-1:0]; lookup_tag_i = lt; lookup_word_i = lw[SW-1:0];
    fill_valid_i = fv; fill_index_i = fi[IW-1:0]; fill_tag_i = ft; fill_data_i = fl;
    wr_valid_i = wv; wr_index_i = wi[IW-1:0]; wr_way_i = wy[AW-1:0]; wr_word_i = wd[SW-1:0]; wr_data_i = wdat;
    flush_req_i = fr;
    model_lookup(li, lt, lw, mh, mw, md);
    mv = victim(fi);
    wok = wv && mvalid[wy][wi] && !(fv && fi == wi && mv == wy);
    if (fv) begin
      allv = 1;
      for (int w = 0; w < W; w++) if (!mvalid[w][fi]) allv = 0;
      mvalid[mv][fi] = 1; mtag[mv][fi] = ft;
      for (int k = 0; k < WPL; k++) mdata[mv][fi][k] = fl[k*WW +: WW];
      if (allv) mptr[fi] = (mptr[fi] + 1) % W;
    end
    if (wok) mdata[wy][wi][wd] = wdat;
    #1;
    dfw = fill_way_o;
    drdy = lookup_ready_o & fill_ready_o;
    tick();
    lookup_valid_i = 0; fill_valid_i = 0; wr_valid_i = 0; flush_req_i = 0;
  endtask

  function automatic logic [LW-1:0] seq_line(input logic [WW-1:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < WPL; k++) l[k*WW +: WW] = base + WW'(k);
    return l;
  endfunction

  task automatic lk(input int idx, input logic [TF-1:0] tag, input int wd);
    cyc(1, idx, tag, wd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fl(input int idx, input logic [TF-1:0] tag, input logic [LW-1:0] l);
    cyc(0, 0, 0, 0, 1, idx, tag, l, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int idx, input int wy, input int wd, input logic [WW-1:0] d);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, idx, wy, wd, d, 0);
  endtask

  typedef struct {
    int op;
    int idx;
    logic [TF-1:0] tag;
    int word;
    logic [WW-1:0] data;
    int way;
    bit ehit;
    int eway;
    logic [WW-1:0] edata;
  } vec_t;
  vec_t vec [12];

  bit sv [W][S];
  logic [TF-1:0] st [W][S];

  initial begin
    int n;
    bit bad;
    vec[0]  = '{0, 5, 20'h12345, 0, 0, 0, 0, 0, 32'h0};
    vec[1]  = '{1, 5, 20'h12345, 0, 32'hA000_0000, 0, 0, 0, 32'h0};
    vec[2]  = '{0, 5, 20'h12345, 3, 0, 0, 1, 0, 32'hA000_0003};
    vec[3]  = '{2, 5, 20'h0, 3, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};
    vec[4]  = '{0, 5, 20'h12345, 3, 0, 0, 1, 0, 32'hDEAD_BEEF};
    vec[5]  = '{0, 5, 20'h12345, 7, 0, 0, 1, 0, 32'hA000_0007};
    vec[6]  = '{0, 5, 20'h12346, 3, 0, 0, 0, 0, 32'h0};
    vec[7]  = '{2, 9, 20'h0, 1, 32'h1111_1111, 0, 0, 0, 32'h0};
    vec[8]  = '{1, 9, 20'h00055, 0, 32'hB000_0000, 0, 0, 0, 32'h0};
    vec[9]  = '{0, 9, 20'h00055, 1, 0, 0, 1, 0, 32'hB000_0001};
    vec[10] = '{1, 5, 20'h00777, 0, 32'hC000_0000, 1, 0, 0, 32'h0};
    vec[11] = '{0, 5, 20'h00777, 2, 0, 0, 1, 1, 32'hC000_0002};
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_flush_busy", flush_busy_o, 0);
    chk("rst_ready", {lookup_ready_o, fill_ready_o}, 2'b11);
    rst_ni = 1;
    tick();

    for (int i = 0; i < 12; i++) begin
      case (vec[i].op)
        0: begin
          lk(vec[i].idx, vec[i].tag, vec[i].word);
          chk($sformatf("vec%0d_valid", i), resp_valid_o, 1);
          chk($sformatf("vec%0d_hit", i), resp_hit_o, vec[i].ehit);
          chk($sformatf("vec%0d_way", i), resp_way_o, vec[i].eway);
          chk($sformatf("vec%0d_data", i), resp_data_o, vec[i].edata);
        end
        1: begin
          fl(vec[i].idx, vec[i].tag, seq_line(vec[i].data));
          chk($sformatf("vec%0d_fill_way", i), dfw, vec[i].way);
        end
        default: begin
          wr(vec[i].idx, vec[i].way, vec[i].word, vec[i].data);
          chk($sformatf("vec%0d_no_resp", i), resp_valid_o, 0);
        end
      endcase
    end

    for (int t = 1; t <= 9; t++) begin
      fl(7, TF'(t), seq_line(32'h7000_0000 + 32'(t << 8)));
      chk($sformatf("set7_fill%0d_way", t), dfw, (t - 1) % 8);
    end
    lk(7, 1, 0);
    chk("set7_tag1_evicted", resp_hit_o, 0);
    lk(7, 9, 2);
    chk("set7_tag9_hit", {resp_hit_o, resp_way_o}, {1'b1, 3'd0});
    chk("set7_tag9_data", resp_data_o, 32'h7000_0902);
    fill_index_i = 7;
    #1;
    chk("set7_pointer", fill_way_o, 1);

    cyc(0, 0, 0, 0, 1, 7, 20'h000AA, seq_line(32'hE000_0000), 1, 7, 1, 0, 32'hFFFF_FFFF, 0);
    chk("fill_vs_write_way", dfw, 1);
    lk(7, 20'h000AA, 0);
    chk("fill_beats_write", {resp_hit_o, resp_way_o, resp_data_o}, {1'b1, 3'd1, 32'hE000_0000});
    cyc(1, 7, 20'h000BB, 4, 1, 7, 20'h000BB, seq_line(32'hF000_0000), 0, 0, 0, 0, 0, 0);
    chk("rbw_lookup_miss", {resp_valid_o, resp_hit_o}, 2'b10);
    lk(7, 20'h000BB, 4);
    chk("rbw_then_hit", {resp_hit_o, resp_way_o, resp_data_o}, {1'b1, 3'd2, 32'hF000_0004});

    for (int i = 0; i < 400; i++) begin
      logic [LW-1:0] rl;
      bit lv, fv, wv;
      for (int k = 0; k < WPL; k++) rl[k*WW +: WW] = $urandom;
      lv = $urandom_range(0, 1); fv = ($urandom_range(0, 3) == 0); wv = $urandom_range(0, 1);
      cyc(lv, $urandom_range(0, 3), TF'($urandom_range(0, 5)), $urandom_range(0, 7),
          fv, $urandom_range(0, 3), TF'($urandom_range(0, 5)), rl,
          wv, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom, 0);
      if (fv) chk("rnd_fill_way", dfw, mv);
      chk("rnd_resp_valid", resp_valid_o, lv);
      if (lv) chk("rnd_resp", {resp_hit_o, resp_way_o, resp_data_o}, {mh, 3'(mw), md});
    end

    sv = mvalid; st = mtag;
    cyc(1, 7, 20'h000AA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_start_lookup", {resp_valid_o, resp_hit_o, resp_data_o}, {1'b1, mh, md});
    n = 0; bad = 0;
    while (flush_busy_o && n < 300) begin
      if (lookup_ready_o || fill_ready_o) bad = 1;
      flush_req_i = (n < 100);
      n++;
      tick();
    end
    flush_req_i = 0;
    chk("flush_cycles", n, 128);
    chk("flush_ready_low", bad, 0);
    model_clear();
    for (int j = 0; j < 7; j++) begin
      int idx;
      idx = (j < 4) ? j : (j == 4 ? 5 : (j == 5 ? 7 : 9));
      for (int w = 0; w < W; w++)
        if (sv[w][idx]) begin
          lk(idx, st[w][idx], 0);
          chk($sformatf("post_flush_miss_s%0d_w%0d", idx, w), {resp_hit_o, resp_data_o}, 33'h0);
        end
    end
    fill_index_i = 7;
    #1;
    chk("post_flush_ptr7", fill_way_o, 0);

    fl(5, 20'h00042, seq_line(32'h4200_0000));
    lk(5, 20'h00042, 1);
    chk("pre_rst_hit", {resp_hit_o, resp_data_o}, {1'b1, 32'h4200_0001});
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (39) tick();
    chk("flush40_busy", flush_busy_o, 1);
    lookup_valid_i = 1; lookup_index_i = 5; lookup_tag_i = 20'h00042;
    rst_ni = 0;
    #1;
    chk("rst_mid_flush_busy", flush_busy_o, 0);
    chk("rst_mid_flush_ready", lookup_ready_o, 1);
    tick();
    chk("rst_mid_resp_valid", resp_valid_o, 0);
    lookup_valid_i = 0;
    rst_ni = 1;
    model_clear();
    lk(5, 20'h00042, 1);
    chk("post_rst_miss", {resp_valid_o, resp_hit_o, resp_data_o}, {1'b1, 1'b0, 32'h0});
    fill_index_i = 5;
    #1;
    chk("post_rst_victim", fill_way_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
